// File: rtl/edly_pkg.sv
// Shared defaults, width helpers and entry types for the event delay scheduler.
package edly_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int MAX_DELAY_DEF = 1023;
  localparam int DEPTH_DEF     = 8;
  localparam int RST_DELAY_DEF = 10;

  function automatic int dly_w(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // One extra timestamp bit keeps due == now unambiguous across a counter wrap.
  function automatic int ts_w(input int max_delay);
    return dly_w(max_delay) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [ts_w(MAX_DELAY_DEF)-1:0] ts_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    ts_t                   due;
    logic                  ripe;
  } entry_t;

endpackage

// File: rtl/event_delay_scheduler_if.sv
// Valid/ready event stream into and out of the delay scheduler; slave is the scheduler side.
interface event_delay_scheduler_if #(
  parameter int DATA_W = edly_pkg::DATA_W_DEF
);
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_ready_i;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/edly_entry_fifo.sv
// Circular buffer of {data, due, ripe} entries; each slot latches ripe when its due time arrives.
// Push/pop take effect at the edge; flush clears pointers, level and ripe bits and dominates both.
module edly_entry_fifo
  import edly_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  TS_W   = ts_w(MAX_DELAY_DEF),
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int LVL_W  = lvl_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [TS_W-1:0]   push_due_i,
  input  logic              push_ripe_i,
  input  logic [TS_W-1:0]   now_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [TS_W-1:0]   head_due_o,
  output logic              head_ripe_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   due;
    logic              ripe;
  } slot_t;

  slot_t             mem_q [DEPTH];
  slot_t             mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    // Free slots may match too; harmless because a push rewrites the ripe bit.
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i].ripe = mem_q[i].ripe | (mem_q[i].due == now_i);
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].ripe = 1'b0;
      end
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q].data = push_data_i;
        mem_d[wr_q].due  = push_due_i;
        mem_d[wr_q].ripe = push_ripe_i;
        wr_d             = wr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_d = rd_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   lvl_d = lvl_q + LVL_W'(1);
        2'b01:   lvl_d = lvl_q - LVL_W'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  assign head_data_o = mem_q[rd_q].data;
  assign head_due_o  = mem_q[rd_q].due;
  assign head_ripe_o = mem_q[rd_q].ripe;
  assign full_o      = (lvl_q == LVL_W'(DEPTH));
  assign empty_o     = (lvl_q == '0);
  assign level_o     = lvl_q;

endmodule

// File: rtl/event_delay_scheduler.sv
// Re-emits each accepted event max(delay,1) cycles later, in order, up to DEPTH in flight.
// Backpressure or enable_i low only postpones emission; ripe entries wait and then drain one per cycle.
module event_delay_scheduler
  import edly_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  MAX_DELAY = MAX_DELAY_DEF,
  parameter int  DEPTH     = DEPTH_DEF,
  parameter int  RST_DELAY = RST_DELAY_DEF,
  localparam int DLY_W     = dly_w(MAX_DELAY),
  localparam int LVL_W     = lvl_w(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic                     cfg_load_i,
  input  logic [DLY_W-1:0]         cfg_delay_i,
  output logic                     cfg_err_o,
  event_delay_scheduler_if.slave   io,
  output logic [LVL_W-1:0]         level_o,
  output logic                     busy_o
);

  localparam int TS_W = ts_w(MAX_DELAY);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic              cfg_err_q, cfg_err_d;

  logic              in_ready, accept, out_valid, pop, cfg_ok;
  logic [TS_W-1:0]   push_due;
  logic              push_ripe;
  logic [DATA_W-1:0] head_data;
  logic [TS_W-1:0]   head_due;
  logic              head_ripe, full, empty;
  logic [DLY_W:0]    cfg_ext;

  always_comb begin
    in_ready  = enable_i & ~full & ~flush_i;
    accept    = io.in_valid_i & in_ready;
    push_due  = ts_q + TS_W'(delay_q);
    push_ripe = (delay_q == '0);
    // The head may come due this very cycle, before its ripe bit has latched.
    out_valid = enable_i & ~empty & ~flush_i & (head_ripe | (head_due == ts_q));
    pop       = out_valid & io.out_ready_i;
    // Delay changes only while empty, so due order always equals FIFO order.
    cfg_ok    = cfg_load_i & empty & ~accept & ~flush_i;
    cfg_ext   = {1'b0, cfg_delay_i};
    ts_d      = ts_q + TS_W'(1);
    delay_d   = delay_q;
    if (cfg_ok) begin
      if (cfg_ext > (DLY_W + 1)'(MAX_DELAY)) begin
        delay_d = DLY_W'(MAX_DELAY);
      end else begin
        delay_d = cfg_delay_i;
      end
    end
    cfg_err_d = cfg_load_i & ~cfg_ok;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q      <= '0;
      delay_q   <= DLY_W'(RST_DELAY);
      cfg_err_q <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      delay_q   <= delay_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  edly_entry_fifo #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (accept),
    .pop_i       (pop),
    .push_data_i (io.in_data_i),
    .push_due_i  (push_due),
    .push_ripe_i (push_ripe),
    .now_i       (ts_q),
    .head_data_o (head_data),
    .head_due_o  (head_due),
    .head_ripe_o (head_ripe),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level_o)
  );

  assign io.in_ready_o  = in_ready;
  assign io.out_valid_o = out_valid;
  assign io.out_data_o  = empty ? '0 : head_data;
  assign cfg_err_o      = cfg_err_q;
  assign busy_o         = (level_o != '0);

endmodule
